// File: rtl/ryuki_datatypes_pkg.sv
// rtl/ryuki_datatypes_pkg.sv - trace record type, stream header field positions and serialiser states
package ryuki_datatypes;

  // One trace record as produced by the trace unit. The first member is the MSB end,
  // so pc occupies bits [31:0] and is the first payload beat on the stream.
  typedef struct packed {
    logic [7:0]  flags;
    logic [31:0] instr;
    logic [31:0] pc;
  } trace_output;

  // Header word field positions
  localparam int TRACE_HDR_DROP_BIT  = 31;
  localparam int TRACE_HDR_BEATS_MSB = 30;
  localparam int TRACE_HDR_BEATS_LSB = 24;
  localparam int TRACE_HDR_SEQ_MSB   = 15;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } trace_ser_state_t;

endpackage

// File: rtl/trace_record_fifo.sv
// rtl/trace_record_fifo.sv - show-ahead record FIFO with full/empty/level flags
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en_i, wr_data_i    write request and record (ignored when full)
//   rd_en_i, rd_data_o    pop request (ignored when empty); rd_data_o is the current head
//   full_o, empty_o       occupancy flags from registered pointers
//   level_o               number of records held
module trace_record_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one extra wrap bit: equal low bits with differing MSBs means full.
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_wr    = wr_en_i && !full_o;
  assign do_rd    = rd_en_i && !empty_o;
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is read until the pointers say it was written.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/trace_stream_serialiser.sv
// rtl/trace_stream_serialiser.sv - buffers trace records and emits them as framed stream packets
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   enable_i                    capture enable
//   trace_data_ready            single-cycle record strobe from the trace unit
//   trace_data_i                trace record
//   stream_valid_o/data_o/last_o/ready_i   outgoing word stream (header + payload beats)
//   fifo_level_o                records currently buffered
//   drop_count_o                saturating count of records lost to a full FIFO
module trace_stream_serialiser
  import ryuki_datatypes::*;
#(
  parameter int DEPTH     = 8,
  parameter int OUT_WIDTH = 32,
  parameter int SEQ_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic                   trace_data_ready,
  input  trace_output            trace_data_i,
  output logic                   stream_valid_o,
  output logic [OUT_WIDTH-1:0]   stream_data_o,
  output logic                   stream_last_o,
  input  logic                   stream_ready_i,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic [15:0]            drop_count_o
);

  localparam int REC_W  = $bits(trace_output);
  localparam int BEATS  = (REC_W + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int PAD_W  = BEATS * OUT_WIDTH;
  localparam int BEAT_W = $clog2(BEATS) + 1;

  logic             capture;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] fifo_rd_data;
  logic             drop;

  trace_ser_state_t     state_q, state_d;
  logic [PAD_W-1:0]     shift_q, shift_d;
  logic [OUT_WIDTH-1:0] hdr_q, hdr_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic                 drop_flag_q, drop_flag_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic                 last_beat;

  // Fullness is the registered value, so a pop on the same edge does not make room.
  assign capture   = enable_i && trace_data_ready;
  assign fifo_push = capture && !fifo_full;
  assign drop      = capture && fifo_full;

  trace_record_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .wr_en_i   (fifo_push),
    .wr_data_i (trace_data_i),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level_o)
  );

  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    hdr_d          = hdr_q;
    beat_d         = beat_q;
    seq_d          = seq_q;
    fifo_pop       = 1'b0;
    stream_valid_o = 1'b0;
    stream_last_o  = 1'b0;
    stream_data_o  = '0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          // Record is zero-extended so the final beat comes out padded.
          shift_d  = PAD_W'(fifo_rd_data);
          hdr_d    = '0;
          hdr_d[TRACE_HDR_DROP_BIT]                      = drop_flag_q;
          hdr_d[TRACE_HDR_BEATS_MSB:TRACE_HDR_BEATS_LSB] = 7'(BEATS);
          hdr_d[SEQ_WIDTH-1:0]                           = seq_q;
          state_d  = HEADER;
        end
      end

      HEADER: begin
        stream_valid_o = 1'b1;
        stream_data_o  = hdr_q;
        if (stream_ready_i) begin
          beat_d  = '0;
          state_d = PAYLOAD;
        end
      end

      PAYLOAD: begin
        stream_valid_o = 1'b1;
        stream_data_o  = shift_q[OUT_WIDTH-1:0];
        stream_last_o  = last_beat;
        if (stream_ready_i) begin
          if (last_beat) begin
            seq_d   = seq_q + SEQ_WIDTH'(1);
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            shift_d = shift_q >> OUT_WIDTH;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // A drop on the same edge as a header pop is reported in the following header.
  always_comb begin
    drop_flag_d = drop_flag_q;
    if (drop) begin
      drop_flag_d = 1'b1;
    end else if (fifo_pop) begin
      drop_flag_d = 1'b0;
    end
  end

  assign drop_cnt_d   = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  assign drop_count_o = drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hdr_q       <= '0;
      beat_q      <= '0;
      seq_q       <= '0;
      drop_flag_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hdr_q       <= hdr_d;
      beat_q      <= beat_d;
      seq_q       <= seq_d;
      drop_flag_q <= drop_flag_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule
